// File: rtl/detector_jogada_if.sv
`default_nettype none
// ============================================================================
// Module      : detector_jogada_if
// Description : Signal bundle between the play detector and its environment.
//               master : drives habilita/botoes, observes the detector outputs
//               slave  : the detector itself
// Ports       : habilita      - a new play may be accepted
//               botoes[3:0]   - raw push-button levels, 1 = pressed
//               jogada_feita  - one-cycle pulse, accepted play
//               jogada[3:0]   - last accepted play (registered)
//               invalida      - one-cycle pulse, rejected multi-key press
//               db_tem_jogada - debug, a press is being processed
//               db_estado[2:0]- debug, current state code
// Revision    : 1.0 - initial release
// ============================================================================
interface detector_jogada_if;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       invalida;
    logic       db_tem_jogada;
    logic [2:0] db_estado;

    modport master (
        output habilita, botoes,
        input  jogada_feita, jogada, invalida, db_tem_jogada, db_estado
    );

    modport slave (
        input  habilita, botoes,
        output jogada_feita, jogada, invalida, db_tem_jogada, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
// Module      : detector_jogada
// Description : Debounces four raw push buttons and reports one play per
//               physical press. A press must be stable for N_DEB cycles to be
//               accepted and the buttons must then read all-zero for N_DEB
//               cycles before another press is considered.
// Parameters  : N_DEB - stable cycles needed to accept press/release (>= 2)
// Macro       : UNICA_TECLA_EN - when defined, presses with more than one key
//               are rejected with an invalida pulse instead of a play.
// Ports       : clock - system clock, rising edge
//               reset - synchronous, active-low
//               jog   - detector_jogada_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module detector_jogada #(
    parameter int N_DEB = 50000
) (
    input  logic             clock,
    input  logic             reset,
    detector_jogada_if.slave jog
);

    // Smallest width that holds N_DEB-1.
    localparam int CNT_W = $clog2(N_DEB);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(N_DEB - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        DEBOUNCE = 3'd1,
        EMITE    = 3'd2,
        SOLTA    = 3'd3
    } estado_t;

    estado_t          r_estado;
    estado_t          w_prox_estado;
    logic [3:0]       r_sinc_a;
    logic [3:0]       r_sinc_b;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand;
    logic [3:0]       r_jogada;
    logic [3:0]       w_jogada;
    logic             w_feita;
    logic             w_invalida;

`ifdef UNICA_TECLA_EN
    // Clearing the lowest set bit leaves something only if 2+ bits are set.
    logic w_multi;
    assign w_multi = |(r_cand & (r_cand - 4'd1));
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sinc_a <= 4'd0;
            r_sinc_b <= 4'd0;
            r_estado <= ESPERA;
            r_cnt    <= '0;
            r_cand   <= 4'd0;
            r_jogada <= 4'd0;
        end else begin
            r_sinc_a <= jog.botoes;
            r_sinc_b <= r_sinc_a;
            r_estado <= w_prox_estado;
            r_cnt    <= w_cnt;
            r_cand   <= w_cand;
            r_jogada <= w_jogada;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic. Every transition clears the counter, so
    // it never needs to count past N_DEB-1.
    // ------------------------------------------------------------------
    always_comb begin
        w_prox_estado = r_estado;
        w_cnt         = r_cnt;
        w_cand        = r_cand;
        w_jogada      = r_jogada;
        w_feita       = 1'b0;
        w_invalida    = 1'b0;

        case (r_estado)
            ESPERA: begin
                if ((r_sinc_b != 4'd0) && jog.habilita) begin
                    w_cand        = r_sinc_b;
                    w_cnt         = '0;
                    w_prox_estado = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if ((r_sinc_b != r_cand) || !jog.habilita) begin
                    w_cnt         = '0;
                    w_prox_estado = ESPERA;
                end else if (r_cnt == c_cnt_max) begin
                    w_cnt         = '0;
                    w_prox_estado = EMITE;
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end

            EMITE: begin
                w_cnt         = '0;
                w_prox_estado = SOLTA;
`ifdef UNICA_TECLA_EN
                if (w_multi) begin
                    w_invalida = 1'b1;
                end else begin
                    w_feita  = 1'b1;
                    w_jogada = r_cand;
                end
`else
                w_feita  = 1'b1;
                w_jogada = r_cand;
`endif
            end

            SOLTA: begin
                // Any key seen restarts the release count.
                if (r_sinc_b != 4'd0) begin
                    w_cnt = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_cnt         = '0;
                    w_prox_estado = ESPERA;
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_cnt         = '0;
                w_prox_estado = ESPERA;
            end
        endcase
    end

    assign jog.jogada_feita  = w_feita;
    assign jog.invalida      = w_invalida;
    assign jog.jogada        = r_jogada;
    assign jog.db_estado     = r_estado;
    assign jog.db_tem_jogada = (r_estado == DEBOUNCE) || (r_estado == EMITE) ||
                               (r_estado == SOLTA);

endmodule
`default_nettype wire

// File: tb/tb_detector_jogada.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_jogada
// Description : Self-checking bench for detector_jogada with N_DEB = 4.
//               A cycle-accurate vector table covers reset and a first press/
//               release; directed sequences cover bounce, long hold, habilita
//               gating, multi-key presses and reset during debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_jogada;

    localparam int N_DEB = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    detector_jogada_if u_if ();

    detector_jogada #(.N_DEB(N_DEB)) u_dut (
        .clock (clock),
        .reset (reset),
        .jog   (u_if)
    );

    int n_cmp      = 0;
    int n_err      = 0;
    int n_edge     = 0;
    int n_feita    = 0;
    int n_inval    = 0;
    int edge_feita = -1;

    typedef struct packed {
        logic       rst;
        logic       hab;
        logic [3:0] bot;
        logic [2:0] estado;
        logic       tem;
        logic       feita;
        logic [3:0] jog;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 ns later and pulses tallied.
    task automatic step();
        @(posedge clock);
        #1;
        n_edge++;
        if (u_if.jogada_feita === 1'b1) begin
            n_feita++;
            edge_feita = n_edge;
        end
        if (u_if.invalida === 1'b1) n_inval++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while (u_if.db_estado !== 3'd0 && k < max) begin
            step();
            k++;
        end
        check(name, 32'(u_if.db_estado), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, hab, bot, estado, tem, feita, jogada (state after the edge)
        vt[0]  = '{1'b0, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000};
        vt[1]  = '{1'b0, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000};
        vt[2]  = '{1'b1, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000};
        vt[3]  = '{1'b1, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000};
        vt[4]  = '{1'b1, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 4'b0000};
        vt[5]  = '{1'b1, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 4'b0000};
        vt[6]  = '{1'b1, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 4'b0000};
        vt[7]  = '{1'b1, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 4'b0000};
        vt[8]  = '{1'b1, 1'b1, 4'b0010, 3'd2, 1'b1, 1'b1, 4'b0000};
        vt[9]  = '{1'b1, 1'b1, 4'b0010, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[10] = '{1'b1, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[11] = '{1'b1, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[12] = '{1'b1, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[13] = '{1'b1, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[14] = '{1'b1, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 4'b0010};
        vt[15] = '{1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0010};

        // ---- table: reset with key held, first play, release ----
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v = vt[i];
            reset         = v.rst;
            u_if.habilita = v.hab;
            u_if.botoes   = v.bot;
            step();
            check($sformatf("vec%0d_estado", i), 32'(u_if.db_estado), 32'(v.estado));
            check($sformatf("vec%0d_tem", i), 32'(u_if.db_tem_jogada), 32'(v.tem));
            check($sformatf("vec%0d_feita", i), 32'(u_if.jogada_feita), 32'(v.feita));
            check($sformatf("vec%0d_jogada", i), 32'(u_if.jogada), 32'(v.jog));
            check($sformatf("vec%0d_invalida", i), 32'(u_if.invalida), 32'd0);
        end

        // ---- bounce then steady hold ----
        n_feita = 0;
        for (int i = 0; i < 10; i++) begin
            u_if.botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
        end
        n_edge      = 0;
        edge_feita  = -1;
        u_if.botoes = 4'b0010;
        hold(12);
        check("bounce_pulses", 32'(n_feita), 32'd1);
        check("bounce_latency", 32'(edge_feita), 32'd7);
        check("bounce_solta", 32'(u_if.db_estado), 32'd3);
        u_if.botoes = 4'b0000;
        wait_idle("bounce_idle", 20);

        // ---- long hold, release, press again ----
        n_feita     = 0;
        u_if.botoes = 4'b1000;
        hold(50);
        check("hold_pulses1", 32'(n_feita), 32'd1);
        check("hold_jogada1", 32'(u_if.jogada), 32'h8);
        u_if.botoes = 4'b0000;
        hold(10);
        check("hold_released", 32'(u_if.db_estado), 32'd0);
        u_if.botoes = 4'b1000;
        hold(10);
        check("hold_pulses2", 32'(n_feita), 32'd2);
        check("hold_jogada2", 32'(u_if.jogada), 32'h8);
        u_if.botoes = 4'b0000;
        wait_idle("hold_idle", 20);

        // ---- key held while habilita low, then habilita rises ----
        begin
            int busy;
            busy          = 0;
            n_feita       = 0;
            u_if.habilita = 1'b0;
            u_if.botoes   = 4'b0100;
            for (int i = 0; i < 20; i++) begin
                step();
                if (u_if.db_estado !== 3'd0) busy++;
            end
            check("hab0_busy_cycles", 32'(busy), 32'd0);
            check("hab0_pulses", 32'(n_feita), 32'd0);
        end
        n_edge        = 0;
        edge_feita    = -1;
        u_if.habilita = 1'b1;
        hold(6);
        check("hab1_pulses", 32'(n_feita), 32'd1);
        check("hab1_latency", 32'(edge_feita), 32'd5);
        u_if.habilita = 1'b0;
        hold(4);
        check("hab_ignored_solta", 32'(u_if.db_estado), 32'd3);
        check("hab1_jogada", 32'(u_if.jogada), 32'h4);
        u_if.botoes = 4'b0000;
        hold(5);
        check("release_still_solta", 32'(u_if.db_estado), 32'd3);
        step();
        check("release_espera", 32'(u_if.db_estado), 32'd0);
        u_if.habilita = 1'b1;

        // ---- multi-key press ----
        n_feita     = 0;
        n_inval     = 0;
        u_if.botoes = 4'b0011;
        hold(10);
`ifdef UNICA_TECLA_EN
        check("multi_invalida", 32'(n_inval), 32'd1);
        check("multi_feita", 32'(n_feita), 32'd0);
        check("multi_jogada", 32'(u_if.jogada), 32'h4);
`else
        check("multi_invalida", 32'(n_inval), 32'd0);
        check("multi_feita", 32'(n_feita), 32'd1);
        check("multi_jogada", 32'(u_if.jogada), 32'h3);
`endif
        u_if.botoes = 4'b0000;
        wait_idle("multi_idle", 20);

        // ---- reset during debounce, then key still held ----
        begin
            int k;
            k           = 0;
            n_feita     = 0;
            u_if.botoes = 4'b0001;
            while (u_if.db_estado !== 3'd1 && k < 10) begin
                step();
                k++;
            end
            check("mid_deb_reached", 32'(u_if.db_estado), 32'd1);
        end
        hold(2);
        reset = 1'b0;
        step();
        check("mid_deb_rst_estado", 32'(u_if.db_estado), 32'd0);
        check("mid_deb_rst_jogada", 32'(u_if.jogada), 32'd0);
        check("mid_deb_rst_pulses", 32'(n_feita), 32'd0);
        reset      = 1'b1;
        n_edge     = 0;
        n_feita    = 0;
        edge_feita = -1;
        hold(10);
        check("after_rst_pulses", 32'(n_feita), 32'd1);
        check("after_rst_latency", 32'(edge_feita), 32'd7);
        check("after_rst_jogada", 32'(u_if.jogada), 32'h1);
        u_if.botoes = 4'b0000;
        wait_idle("final_idle", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
- REQ-001 Parameter: N_DEB, default 50000, number of consecutive stable clock cycles required to accept a press or a release (minimum 2).
- REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
- REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
- REQ-004 habilita  input  1  from the control unit; high means a new play may be accepted.
- REQ-005 botoes  input  4  raw, asynchronous, bouncy push-button levels; 1 means pressed.
- REQ-006 jogada_feita  output  1  one-cycle pulse marking an accepted play; drives the datapath's play-detected input.
- REQ-007 jogada  output  4  registered value of the last accepted play; drives the datapath chaves input.
- REQ-008 invalida  output  1  one-cycle pulse marking a rejected multi-key press.
- REQ-009 db_tem_jogada  output  1  high while state is DEBOUNCE, EMITE or SOLTA.
- REQ-010 db_estado  output  3  current state code.

Function
- REQ-011 botoes SHALL pass through a 2-flop synchronizer; only the synchronized value (sinc) feeds the logic below.
- REQ-012 States and codes SHALL be ESPERA=0, DEBOUNCE=1, EMITE=2, SOLTA=3; codes 4-7 SHALL return to ESPERA on the next edge.
- REQ-013 ESPERA: if sinc≠0 and habilita=1, the block SHALL latch sinc into a candidate register, clear the counter and go to DEBOUNCE; otherwise it SHALL stay in ESPERA.
- REQ-014 ESPERA with sinc≠0 and habilita=0 SHALL stay in ESPERA; a key held while habilita rises SHALL then be accepted through DEBOUNCE.
- REQ-015 DEBOUNCE: if sinc≠candidate or habilita=0, the block SHALL go to ESPERA without emitting; otherwise the counter SHALL increment.
- REQ-016 DEBOUNCE: when the counter reaches N_DEB-1 with sinc=candidate, the block SHALL go to EMITE.
- REQ-017 EMITE SHALL last exactly one cycle: jogada_feita=1 and jogada<=candidate at the end of the cycle, then SOLTA with the counter cleared.
- REQ-018 jogada SHALL be stable from the cycle after EMITE until the next EMITE; jogada_feita SHALL be high only in EMITE.
- REQ-019 SOLTA: each cycle with sinc≠0 SHALL clear the counter; each cycle with sinc=0 SHALL increment it; N_DEB consecutive zero cycles SHALL return the block to ESPERA.
- REQ-020 habilita SHALL be ignored in EMITE and SOLTA; one physical press SHALL produce at most one jogada_feita.
- REQ-021 The counter width SHALL be the minimum that holds N_DEB-1; the counter SHALL never wrap, because it is cleared on every state entry.
- REQ-022 Latency: with botoes constant and habilita=1, jogada_feita SHALL rise exactly N_DEB+3 rising edges after the first edge at which botoes is sampled nonzero.

Reset
- REQ-023 With reset=0 at a rising edge, the block SHALL enter ESPERA and set jogada=0, jogada_feita=0, invalida=0, counter=0, candidate=0 and synchronizer flops=0.
- REQ-024 Reset SHALL take priority over every transition, including mid-DEBOUNCE and mid-SOLTA; no pulse SHALL be emitted in the reset cycle or the cycle after it.
- REQ-025 After reset deasserts with a key already held, that key SHALL be accepted as a fresh press subject to habilita.

Configuration
- REQ-026 Macro UNICA_TECLA_EN defined: at DEBOUNCE completion, a candidate with more than one bit set SHALL pulse invalida for one cycle in EMITE, SHALL NOT pulse jogada_feita, SHALL leave jogada unchanged, and SHALL proceed to SOLTA.
- REQ-027 Macro UNICA_TECLA_EN undefined: any nonzero candidate SHALL be accepted and invalida SHALL be tied to 0.

Verification (N_DEB=4)
- REQ-028 Reset: reset=0 for 2 cycles with botoes=4'b0010 -> db_estado=0, jogada=0, no pulses; after release with habilita=1 -> jogada_feita at edge 7, jogada=4'b0010.
- REQ-029 Bounce: botoes toggles 0010/0000 every cycle for 10 cycles, then holds 0010 -> exactly one jogada_feita, 7 edges after the hold starts.
- REQ-030 Hold and release: hold 1000 for 50 cycles, release, press 1000 again -> exactly two jogada_feita pulses; jogada=4'b1000 both times.
- REQ-031 habilita=0 while 0100 is held for 20 cycles, then habilita=1 -> no pulse while habilita=0; one pulse afterwards; db_estado returns to 0 only after release plus 4 zero cycles.
- REQ-032 Multi-key 0011 held -> with UNICA_TECLA_EN: invalida pulses once, jogada keeps its previous value; without the macro: jogada_feita pulses once, jogada=4'b0011.
- REQ-033 Reset mid-DEBOUNCE (reset=0 at counter=2) -> ESPERA next edge, no jogada_feita, jogada unchanged from 0.
